// File: rtl/lcd_monitor.sv
// Passive monitor for the 4-bit character-LCD write bus: reassembles nibbles into
// bytes, decodes controller commands and keeps a shadow DDRAM plus display state.
`timescale 1ns/1ps
module lcd_monitor #(
    parameter int VIS_COLS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_lcd_sf_e,
    input  logic       i_lcd_e,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_d,
    input  logic       i_lcd_c,
    input  logic       i_lcd_b,
    input  logic       i_lcd_a,
    input  logic [4:0] i_rd_addr,
    output logic [7:0] o_rd_char,
    output logic       o_byte_valid,
    output logic       o_byte_rs,
    output logic [7:0] o_byte_val,
    output logic       o_mode4,
    output logic       o_disp_on,
    output logic       o_cursor_on,
    output logic       o_blink_on,
    output logic [6:0] o_cur_addr,
    output logic       o_clr_busy,
    output logic       o_proto_err
);
    localparam int DEPTH = 2 * VIS_COLS;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {S_INIT8, S_M4_HI, S_M4_LO} state_t;

    // Bus bit order: sf_e, e, rs, rw, d, c, b, a
    logic [7:0] w_bus;
    logic [7:0] r_sync1, r_sync2;
    logic [6:0] r_cap;
    logic       r_e_prev;

    state_t     r_state;
    logic [3:0] r_hi;
    logic       r_hi_rs;
    logic       r_id;
    logic       r_cg_sel;
    logic       r_pend_v;
    logic [7:0] r_pend_byte;
    logic       r_pend_rs;
    logic [AW-1:0] r_clr_idx;
    logic [6:0] r_cur_addr;
    logic       r_clr_busy;
    logic [7:0] r_shadow [DEPTH];

    logic       w_event, w_rs, w_new_v, w_dec_pend, w_dec_v, w_dec_rs, w_vis, w_wr_en;
    logic [3:0] w_nib;
    logic [7:0] w_new_byte, w_dec_byte, w_wr_data;
    logic [AW-1:0] w_vis_idx, w_wr_idx;

    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
        if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    assign w_bus = {i_lcd_sf_e, i_lcd_e, i_lcd_rs, i_lcd_rw, i_lcd_d, i_lcd_c, i_lcd_b, i_lcd_a};

    // r_cap holds the last synchronized sample with e high, so data that changes
    // together with the falling edge of e is never captured.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cap    <= '0;
            r_e_prev <= 1'b0;
        end else begin
            r_sync1  <= w_bus;
            r_sync2  <= r_sync1;
            r_e_prev <= r_sync2[6];
            if (r_sync2[6])
                r_cap <= {r_sync2[7], r_sync2[5:0]};
        end
    end

    assign w_nib   = r_cap[3:0];
    assign w_rs    = r_cap[5];
    assign w_event = r_e_prev & ~r_sync2[6] & r_cap[6] & ~r_cap[4];

    assign w_new_v    = w_event && (r_state == S_M4_LO) && (w_rs == r_hi_rs);
    assign w_new_byte = {r_hi, w_nib};

    // A pending byte always goes before a freshly completed one.
    assign w_dec_pend = ~r_clr_busy & r_pend_v;
    assign w_dec_v    = w_dec_pend | (w_new_v & ~r_clr_busy & ~r_pend_v);
    assign w_dec_byte = w_dec_pend ? r_pend_byte : w_new_byte;
    assign w_dec_rs   = w_dec_pend ? r_pend_rs : w_rs;

    assign w_vis     = int'(r_cur_addr[5:0]) < VIS_COLS;
    assign w_vis_idx = AW'(int'(r_cur_addr[5:0]) + (r_cur_addr[6] ? VIS_COLS : 0));

    assign w_wr_en   = r_clr_busy | (w_dec_v & w_dec_rs & ~r_cg_sel & w_vis);
    assign w_wr_idx  = r_clr_busy ? r_clr_idx : w_vis_idx;
    assign w_wr_data = r_clr_busy ? 8'h20 : w_dec_byte;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_shadow[i] <= 8'h20;
            o_rd_char <= 8'h20;
        end else begin
            if (w_wr_en)
                r_shadow[w_wr_idx] <= w_wr_data;
            o_rd_char <= (int'(i_rd_addr) < DEPTH) ? r_shadow[AW'(i_rd_addr)] : 8'h20;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_INIT8;
            r_hi         <= '0;
            r_hi_rs      <= 1'b0;
            r_id         <= 1'b1;
            r_cg_sel     <= 1'b0;
            r_pend_v     <= 1'b0;
            r_pend_byte  <= '0;
            r_pend_rs    <= 1'b0;
            r_clr_idx    <= '0;
            r_clr_busy   <= 1'b0;
            r_cur_addr   <= '0;
            o_byte_valid <= 1'b0;
            o_byte_rs    <= 1'b0;
            o_byte_val   <= '0;
            o_mode4      <= 1'b0;
            o_disp_on    <= 1'b0;
            o_cursor_on  <= 1'b0;
            o_blink_on   <= 1'b0;
            o_proto_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;

            if (w_event) begin
                case (r_state)
                    S_INIT8: begin
                        if (!w_rs && w_nib == 4'h3) begin
                            o_byte_valid <= 1'b1;
                            o_byte_val   <= 8'h30;
                            o_byte_rs    <= 1'b0;
                        end else if (!w_rs && w_nib == 4'h2) begin
                            o_byte_valid <= 1'b1;
                            o_byte_val   <= 8'h20;
                            o_byte_rs    <= 1'b0;
                            o_mode4      <= 1'b1;
                            r_state      <= S_M4_HI;
                        end else begin
                            o_proto_err  <= 1'b1;
                        end
                    end
                    S_M4_HI: begin
                        r_hi    <= w_nib;
                        r_hi_rs <= w_rs;
                        r_state <= S_M4_LO;
                    end
                    S_M4_LO: begin
                        r_state <= S_M4_HI;
                        if (w_rs != r_hi_rs) begin
                            o_proto_err <= 1'b1;
                        end else begin
                            o_byte_valid <= 1'b1;
                            o_byte_val   <= w_new_byte;
                            o_byte_rs    <= w_rs;
                        end
                    end
                    default: r_state <= S_INIT8;
                endcase
            end

            if (w_dec_pend) begin
                r_pend_v    <= w_new_v;
                r_pend_byte <= w_new_byte;
                r_pend_rs   <= w_rs;
            end else if (w_new_v && r_clr_busy) begin
                if (r_pend_v) begin
                    o_proto_err <= 1'b1;
                end else begin
                    r_pend_v    <= 1'b1;
                    r_pend_byte <= w_new_byte;
                    r_pend_rs   <= w_rs;
                end
            end

            if (r_clr_busy) begin
                r_clr_idx <= r_clr_idx + AW'(1);
                if (r_clr_idx == AW'(DEPTH - 1))
                    r_clr_busy <= 1'b0;
            end

            if (w_dec_v) begin
                if (w_dec_rs) begin
                    r_cur_addr <= f_step(r_cur_addr, r_id);
                end else begin
                    casez (w_dec_byte)
                        8'b1???????: begin
                            r_cur_addr <= w_dec_byte[6:0];
                            r_cg_sel   <= 1'b0;
                        end
                        8'b01??????: r_cg_sel <= 1'b1;
                        8'b001?????: ;
                        8'b0001????: begin
                            if (!w_dec_byte[3])
                                r_cur_addr <= f_step(r_cur_addr, w_dec_byte[2]);
                        end
                        8'b00001???: begin
                            o_disp_on   <= w_dec_byte[2];
                            o_cursor_on <= w_dec_byte[1];
                            o_blink_on  <= w_dec_byte[0];
                        end
                        8'b000001??: r_id <= w_dec_byte[1];
                        8'b0000001?: r_cur_addr <= '0;
                        8'b00000001: begin
                            r_clr_busy <= 1'b1;
                            r_clr_idx  <= '0;
                            r_cur_addr <= '0;
                            r_id       <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_cur_addr = r_cur_addr;
    assign o_clr_busy = r_clr_busy;

endmodule

// File: tb/tb_lcd_monitor.sv
// Directed bench for lcd_monitor: drives LCD bus nibbles and checks decoded bytes,
// shadow contents and control state against hand-computed values.
`timescale 1ns/1ps
module tb_lcd_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_sf_e, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_nib;
    logic [4:0] rd_addr;
    logic [7:0] o_rd_char, o_byte_val;
    logic       o_byte_valid, o_byte_rs, o_mode4, o_disp_on, o_cursor_on, o_blink_on;
    logic [6:0] o_cur_addr;
    logic       o_clr_busy, o_proto_err;

    int checks = 0;
    int errors = 0;
    int log_n = 0;
    int busy_cnt = 0;
    logic [8:0] log_q [0:31];

    always #10 clk = ~clk;

    lcd_monitor #(.VIS_COLS(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lcd_sf_e(lcd_sf_e), .i_lcd_e(lcd_e), .i_lcd_rs(lcd_rs), .i_lcd_rw(lcd_rw),
        .i_lcd_d(lcd_nib[3]), .i_lcd_c(lcd_nib[2]), .i_lcd_b(lcd_nib[1]), .i_lcd_a(lcd_nib[0]),
        .i_rd_addr(rd_addr), .o_rd_char(o_rd_char),
        .o_byte_valid(o_byte_valid), .o_byte_rs(o_byte_rs), .o_byte_val(o_byte_val),
        .o_mode4(o_mode4), .o_disp_on(o_disp_on), .o_cursor_on(o_cursor_on),
        .o_blink_on(o_blink_on), .o_cur_addr(o_cur_addr),
        .o_clr_busy(o_clr_busy), .o_proto_err(o_proto_err)
    );

    // Record every decoded byte and count sweep cycles
    always @(negedge clk) begin
        if (o_byte_valid) begin
            if (log_n < 32) log_q[log_n] <= {o_byte_rs, o_byte_val};
            log_n <= log_n + 1;
        end
        if (o_clr_busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nib(input logic rs, input logic [3:0] n, input logic rw,
                       input logic sfe, input logic skew);
        lcd_rs = rs; lcd_rw = rw; lcd_sf_e = sfe; lcd_nib = n; lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        lcd_e = 1'b0;
        if (skew) lcd_nib = ~n;
        repeat (4) @(posedge clk);
        #1;
        lcd_rw = 1'b0; lcd_sf_e = 1'b1;
    endtask

    task automatic wbyte(input logic rs, input logic [7:0] b);
        nib(rs, b[7:4], 1'b0, 1'b1, 1'b0);
        nib(rs, b[3:0], 1'b0, 1'b1, 1'b0);
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string tag);
        rd_addr = a[4:0];
        @(posedge clk);
        #1;
        check(tag, {24'h0, o_rd_char}, {24'h0, exp});
    endtask

    int b0;

    initial begin
        lcd_sf_e = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_nib = 4'h0;
        rd_addr = 5'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_byte_valid", 32'(o_byte_valid), 0);
        check("rst_byte_val",   32'(o_byte_val), 0);
        check("rst_byte_rs",    32'(o_byte_rs), 0);
        check("rst_mode4",      32'(o_mode4), 0);
        check("rst_disp",       32'({o_disp_on, o_cursor_on, o_blink_on}), 0);
        check("rst_cur_addr",   32'(o_cur_addr), 0);
        check("rst_clr_busy",   32'(o_clr_busy), 0);
        check("rst_proto_err",  32'(o_proto_err), 0);
        check("rst_rd_char",    32'(o_rd_char), 32'h20);

        // First init nibble, with pin-to-pulse latency measured
        lcd_rs = 1'b0; lcd_nib = 4'h3; lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lat_2clk_low", 32'(o_byte_valid), 0);
        @(negedge clk);
        check("lat_3clk_high", 32'(o_byte_valid), 1);
        check("lat_val", 32'(o_byte_val), 32'h30);
        @(posedge clk);
        #1;
        check("mode4_after_3", 32'(o_mode4), 0);
        nib(1'b0, 4'h3, 1'b0, 1'b1, 1'b0);
        nib(1'b0, 4'h3, 1'b0, 1'b1, 1'b0);
        nib(1'b0, 4'h2, 1'b0, 1'b1, 1'b0);
        check("init_count", log_n, 4);
        check("init_byte2", 32'(log_q[2]), 32'h030);
        check("init_byte3", 32'(log_q[3]), 32'h020);
        check("init_mode4", 32'(o_mode4), 1);

        wbyte(1'b0, 8'h28);
        wbyte(1'b0, 8'h0C);
        check("fnset_byte", 32'(log_q[4]), 32'h028);
        check("dispctl_count", log_n, 6);
        check("dispctl_dcb", 32'({o_disp_on, o_cursor_on, o_blink_on}), 32'h4);

        // Clear, then data that lands while the sweep is still running
        b0 = busy_cnt;
        wbyte(1'b0, 8'h01);
        check("clr_busy_start", 32'(o_clr_busy), 1);
        wbyte(1'b1, 8'h50);
        check("clr_busy_pending", 32'(o_clr_busy), 1);
        check("pending_addr", 32'(o_cur_addr), 0);
        repeat (40) @(posedge clk);
        #1;
        check("clr_busy_len", busy_cnt - b0, 32);
        check("data_P_log", 32'(log_q[7]), 32'h150);
        check("data_P_addr", 32'(o_cur_addr), 1);
        rd(0, 8'h50, "shadow0_P");
        rd(1, 8'h20, "shadow1_blank");
        check("no_err_yet", 32'(o_proto_err), 0);

        // Wrap from end of line 0 to line 1, invisible write
        wbyte(1'b0, 8'hA7);
        check("set_27", 32'(o_cur_addr), 32'h27);
        wbyte(1'b1, 8'h41);
        check("wrap_27_40", 32'(o_cur_addr), 32'h40);
        rd(16, 8'h20, "invisible_16");
        rd(0, 8'h50, "unchanged_0");

        // Skewed data and interleaved ignored pulses
        wbyte(1'b0, 8'h81);
        nib(1'b1, 4'h5, 1'b0, 1'b1, 1'b1);
        nib(1'b1, 4'h1, 1'b0, 1'b1, 1'b1);
        rd(1, 8'h51, "skew_shadow1");
        nib(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        nib(1'b0, 4'h1, 1'b1, 1'b1, 1'b0);
        nib(1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
        nib(1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
        check("busyread_count", log_n, 13);
        check("busyread_byte", 32'(log_q[12]), 32'h152);
        rd(2, 8'h52, "busyread_shadow2");
        check("busyread_addr", 32'(o_cur_addr), 3);

        // RS mismatch between halves
        nib(1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
        nib(1'b0, 4'h1, 1'b0, 1'b1, 1'b0);
        check("rsmis_err", 32'(o_proto_err), 1);
        check("rsmis_nobyte", log_n, 13);
        wbyte(1'b1, 8'h53);
        check("rsmis_recover", 32'(log_q[13]), 32'h153);
        rd(3, 8'h53, "rsmis_shadow3");
        check("rsmis_addr", 32'(o_cur_addr), 4);

        // Decrement mode across the line 1 start
        wbyte(1'b0, 8'h04);
        wbyte(1'b0, 8'hC0);
        check("set_40", 32'(o_cur_addr), 32'h40);
        wbyte(1'b1, 8'h58);
        rd(16, 8'h58, "dec_shadow16");
        check("dec_wrap_27", 32'(o_cur_addr), 32'h27);
        wbyte(1'b0, 8'h10);
        check("shift_left", 32'(o_cur_addr), 32'h26);

        // Reset in the middle of a clear sweep
        wbyte(1'b0, 8'h01);
        repeat (9) @(posedge clk);
        #1;
        check("midclr_busy", 32'(o_clr_busy), 1);
        rst_n = 1'b0;
        #2;
        check("arst_clr_busy", 32'(o_clr_busy), 0);
        check("arst_proto_err", 32'(o_proto_err), 0);
        check("arst_mode4", 32'(o_mode4), 0);
        check("arst_disp", 32'({o_disp_on, o_cursor_on, o_blink_on}), 0);
        check("arst_cur_addr", 32'(o_cur_addr), 0);
        check("arst_byte_val", 32'(o_byte_val), 0);
        check("arst_rd_char", 32'(o_rd_char), 32'h20);
        #5 rst_n = 1'b1;
        for (int i = 0; i < 32; i++)
            rd(i, 8'h20, $sformatf("arst_shadow_%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
